// File: rtl/ctrl_seq.sv
// ID-stage control decoder with registered ID/EX bundle and hazard sequencing
// (load-use stall, branch/jump flush, multi-cycle MUL hold of EX).
module ctrl_seq #(
  parameter int         REG_AW     = 3,
  parameter int         MUL_CYCLES = 4,
  parameter logic [3:0] MUL_OP     = 4'b1101
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        id_op,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic [1:0]        ex_reg_dst,
  output logic [2:0]        ex_alu_op,
  output logic              ex_beq,
  output logic              ex_bgt,
  output logic              ex_ble,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_se_op,
  output logic [1:0]        ex_mem_to_reg,
  output logic              ex_is_mul,
  output logic              mul_busy,
  output logic              mul_done
);

  localparam int CW = $clog2(MUL_CYCLES) + 1;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic [2:0] alu_op;
    logic       beq;
    logic       bgt;
    logic       ble;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       se_op;
    logic [1:0] mem_to_reg;
    logic       is_mul;
  } ctrl_t;

  ctrl_t          dec, ex_q, ex_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy, load_use;

  always_comb begin
    dec = '0;
    case (id_op)
      4'b0010: begin dec.beq = 1'b1; dec.alu_op = 3'b001; end
      4'b0011: begin dec.bgt = 1'b1; dec.alu_op = 3'b001; end
      4'b0100: begin dec.ble = 1'b1; dec.alu_op = 3'b001; end
      4'b0101: begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 2'b01;
        dec.reg_write  = 1'b1;
      end
      4'b0110: dec.mem_write = 1'b1;
      4'b1000, 4'b1001, 4'b1010, 4'b1011,
      4'b1100, 4'b1101, 4'b1110: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = id_op[2:0];
        dec.se_op     = (id_op == 4'b1100) || (id_op == 4'b1101);
        if (id_op == 4'b1011) begin
          dec.reg_dst    = 2'b10;
          dec.mem_to_reg = 2'b10;
        end
      end
      4'b1111: begin
        dec.reg_write = 1'b1;
        dec.reg_dst   = 2'b01;
        dec.alu_op    = 3'b111;
      end
      default: ;
    endcase
    dec.is_mul = (id_op == MUL_OP);
  end

  assign busy     = (cnt_q != '0);
  assign load_use = ex_q.mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (ex_rd == id_rt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  // Flush beats an in-flight MUL; a busy MUL freezes ID/EX so load-use waits.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (branch_taken) begin
      ex_d  = '0;
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q - CW'(1);
    end else if (load_use) begin
      ex_d  = '0;
      cnt_d = '0;
    end else begin
      ex_d  = dec;
      cnt_d = dec.is_mul ? CW'(MUL_CYCLES - 1) : '0;
    end
  end

  always_comb begin
    pc_write    = branch_taken || !(busy || load_use);
    if_id_write = branch_taken || !(busy || load_use);
    if_id_flush = branch_taken || ((id_op == 4'b0001) && !busy);
    mul_busy    = busy;
    mul_done    = ex_q.is_mul && !busy;
  end

  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_beq        = ex_q.beq;
  assign ex_bgt        = ex_q.bgt;
  assign ex_ble        = ex_q.ble;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_se_op      = ex_q.se_op;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_is_mul     = ex_q.is_mul;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed scoreboard bench for ctrl_seq: a MUL_CYCLES=4 instance is fully
// checked, a MUL_CYCLES=1 instance shares the stimulus to show it never stalls.
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] id_op;
  logic [2:0] id_rs, id_rt, ex_rd;
  logic       branch_taken;

  logic       pc_write, if_id_write, if_id_flush;
  logic [1:0] ex_reg_dst, ex_mem_to_reg;
  logic [2:0] ex_alu_op;
  logic       ex_beq, ex_bgt, ex_ble, ex_mem_read, ex_mem_write, ex_reg_write, ex_se_op;
  logic       ex_is_mul, mul_busy, mul_done;

  logic       pc_write_1, if_id_write_1, if_id_flush_1;
  logic [1:0] ex_reg_dst_1, ex_mem_to_reg_1;
  logic [2:0] ex_alu_op_1;
  logic       ex_beq_1, ex_bgt_1, ex_ble_1, ex_mem_read_1, ex_mem_write_1, ex_reg_write_1, ex_se_op_1;
  logic       ex_is_mul_1, mul_busy_1, mul_done_1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [14:0] ex;
    logic        busy;
    logic        done;
    string       tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  ctrl_seq #(.REG_AW(3), .MUL_CYCLES(4), .MUL_OP(4'b1101)) dut (
    .clk(clk), .rst_n(rst_n), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .ex_rd(ex_rd), .branch_taken(branch_taken),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .ex_reg_dst(ex_reg_dst), .ex_alu_op(ex_alu_op), .ex_beq(ex_beq),
    .ex_bgt(ex_bgt), .ex_ble(ex_ble), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_se_op(ex_se_op),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_is_mul(ex_is_mul), .mul_busy(mul_busy),
    .mul_done(mul_done)
  );

  ctrl_seq #(.REG_AW(3), .MUL_CYCLES(1), .MUL_OP(4'b1101)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .ex_rd(ex_rd), .branch_taken(branch_taken),
    .pc_write(pc_write_1), .if_id_write(if_id_write_1), .if_id_flush(if_id_flush_1),
    .ex_reg_dst(ex_reg_dst_1), .ex_alu_op(ex_alu_op_1), .ex_beq(ex_beq_1),
    .ex_bgt(ex_bgt_1), .ex_ble(ex_ble_1), .ex_mem_read(ex_mem_read_1),
    .ex_mem_write(ex_mem_write_1), .ex_reg_write(ex_reg_write_1), .ex_se_op(ex_se_op_1),
    .ex_mem_to_reg(ex_mem_to_reg_1), .ex_is_mul(ex_is_mul_1), .mul_busy(mul_busy_1),
    .mul_done(mul_done_1)
  );

  // Expected ID/EX bundle: {reg_dst, alu_op, beq, bgt, ble, mem_read, mem_write,
  // reg_write, se_op, mem_to_reg, is_mul}, written out per opcode.
  function automatic logic [14:0] ref_dec(input logic [3:0] op);
    logic [1:0] rd, m2r;
    logic [2:0] alu;
    logic       beq, bgt, ble, mr, mw, rw, se, mul;
    {rd, m2r, alu, beq, bgt, ble, mr, mw, rw, se, mul} = '0;
    case (op)
      4'h2: begin beq = 1; alu = 3'b001; end
      4'h3: begin bgt = 1; alu = 3'b001; end
      4'h4: begin ble = 1; alu = 3'b001; end
      4'h5: begin mr = 1; m2r = 2'b01; rw = 1; end
      4'h6: mw = 1;
      4'h8: begin rw = 1; alu = 3'b000; end
      4'h9: begin rw = 1; alu = 3'b001; end
      4'hA: begin rw = 1; alu = 3'b010; end
      4'hB: begin rw = 1; alu = 3'b011; rd = 2'b10; m2r = 2'b10; end
      4'hC: begin rw = 1; alu = 3'b100; se = 1; end
      4'hD: begin rw = 1; alu = 3'b101; se = 1; mul = 1; end
      4'hE: begin rw = 1; alu = 3'b110; end
      4'hF: begin rw = 1; alu = 3'b111; rd = 2'b01; end
      default: ;
    endcase
    return {rd, alu, beq, bgt, ble, mr, mw, rw, se, m2r, mul};
  endfunction

  function automatic logic [16:0] observed();
    return {ex_reg_dst, ex_alu_op, ex_beq, ex_bgt, ex_ble, ex_mem_read, ex_mem_write,
            ex_reg_write, ex_se_op, ex_mem_to_reg, ex_is_mul, mul_busy, mul_done};
  endfunction

  task automatic compare(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    n_cmp++;
    assert (sb.size() > 0) else begin
      n_err++;
      $error("[TB] FAIL scoreboard_underflow: observed 0 entries expected >0");
      return;
    end
    e = sb.pop_front();
    compare(e.tag, observed(), {2'b00, e.ex, e.busy, e.done});
  endtask

  // Drive one ID instruction, check the combinational enables before the edge,
  // queue the expected registered result and check it just after the edge.
  task automatic applyStimulus(input string tag, input logic [3:0] op,
                               input logic [2:0] rs, input logic [2:0] rt,
                               input logic [2:0] rd, input logic bt,
                               input logic e_pc, input logic e_flush,
                               input logic [14:0] e_ex, input logic e_busy,
                               input logic e_done);
    exp_t e;
    @(negedge clk);
    id_op = op; id_rs = rs; id_rt = rt; ex_rd = rd; branch_taken = bt;
    #1;
    compare({tag, "/pc_write"}, 17'(pc_write), 17'(e_pc));
    compare({tag, "/if_id_write"}, 17'(if_id_write), 17'(e_pc));
    compare({tag, "/if_id_flush"}, 17'(if_id_flush), 17'(e_flush));
    e.ex = e_ex; e.busy = e_busy; e.done = e_done; e.tag = {tag, "/ex"};
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    id_op = '0; id_rs = '0; id_rt = '0; ex_rd = '0; branch_taken = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [14:0] ZERO = 15'd0;

  initial begin
    rst_n = 1'b0;
    id_op = '0; id_rs = '0; id_rt = '0; ex_rd = '0; branch_taken = 1'b0;
    #2;
    compare("reset/ex", observed(), 17'd0);
    compare("reset/pc_write", 17'(pc_write), 17'd1);
    compare("reset/if_id_write", 17'(if_id_write), 17'd1);
    compare("reset/if_id_flush", 17'(if_id_flush), 17'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use on rs, then rt, and the ex_rd==0 exemption
    applyStimulus("ld_issue",    4'h5, 3'd0, 3'd0, 3'd0, 0, 1, 0, ref_dec(4'h5), 0, 0);
    applyStimulus("lu_rs_stall", 4'h8, 3'd3, 3'd0, 3'd3, 0, 0, 0, ZERO,          0, 0);
    applyStimulus("lu_rs_issue", 4'h8, 3'd3, 3'd0, 3'd3, 0, 1, 0, ref_dec(4'h8), 0, 0);
    applyStimulus("ld_issue2",   4'h5, 3'd0, 3'd0, 3'd0, 0, 1, 0, ref_dec(4'h5), 0, 0);
    applyStimulus("lu_rd0",      4'h9, 3'd0, 3'd0, 3'd0, 0, 1, 0, ref_dec(4'h9), 0, 0);
    applyStimulus("ld_issue3",   4'h5, 3'd0, 3'd0, 3'd0, 0, 1, 0, ref_dec(4'h5), 0, 0);
    applyStimulus("lu_rt_stall", 4'hA, 3'd1, 3'd2, 3'd2, 0, 0, 0, ZERO,          0, 0);
    applyStimulus("lu_rt_issue", 4'hA, 3'd1, 3'd2, 3'd2, 0, 1, 0, ref_dec(4'hA), 0, 0);

    // MUL holds EX for four cycles; the single-cycle instance never stalls
    applyStimulus("mul_enter",   4'hD, 3'd0, 3'd0, 3'd0, 0, 1, 0, ref_dec(4'hD), 1, 0);
    compare("mul1/flags", 17'({ex_is_mul_1, mul_busy_1, mul_done_1}), 17'b101);
    compare("mul1/pc_write", 17'(pc_write_1), 17'd1);
    applyStimulus("mul_hold1",   4'h8, 3'd0, 3'd0, 3'd0, 0, 0, 0, ref_dec(4'hD), 1, 0);
    applyStimulus("mul_hold2",   4'h8, 3'd0, 3'd0, 3'd0, 0, 0, 0, ref_dec(4'hD), 1, 0);
    applyStimulus("mul_hold3",   4'h8, 3'd0, 3'd0, 3'd0, 0, 0, 0, ref_dec(4'hD), 0, 1);
    applyStimulus("mul_next",    4'h8, 3'd0, 3'd0, 3'd0, 0, 1, 0, ref_dec(4'h8), 0, 0);

    // Back-to-back MULs reload the counter on the second entry edge
    applyStimulus("b2b_first",   4'hD, 3'd0, 3'd0, 3'd0, 0, 1, 0, ref_dec(4'hD), 1, 0);
    for (int k = 0; k < 3; k++)
      applyStimulus("b2b_hold",  4'hD, 3'd0, 3'd0, 3'd0, 0, 0, 0, ref_dec(4'hD), k < 2, k == 2);
    applyStimulus("b2b_second",  4'hD, 3'd0, 3'd0, 3'd0, 0, 1, 0, ref_dec(4'hD), 1, 0);

    // Branch during busy still flushes and clears the counter
    applyStimulus("br_in_busy",  4'h8, 3'd0, 3'd0, 3'd0, 1, 1, 1, ZERO,          0, 0);
    applyStimulus("jmp",         4'h1, 3'd0, 3'd0, 3'd0, 0, 1, 1, ZERO,          0, 0);
    applyStimulus("pre_branch",  4'h9, 3'd0, 3'd0, 3'd0, 0, 1, 0, ref_dec(4'h9), 0, 0);
    applyStimulus("branch",      4'h8, 3'd0, 3'd0, 3'd0, 1, 1, 1, ZERO,          0, 0);

    // A JMP waiting behind a busy MUL does not flush until busy drops
    applyStimulus("jmp_mul",     4'hD, 3'd0, 3'd0, 3'd0, 0, 1, 0, ref_dec(4'hD), 1, 0);
    for (int k = 0; k < 3; k++)
      applyStimulus("jmp_wait",  4'h1, 3'd0, 3'd0, 3'd0, 0, 0, 0, ref_dec(4'hD), k < 2, k == 2);
    applyStimulus("jmp_go",      4'h1, 3'd0, 3'd0, 3'd0, 0, 1, 1, ZERO,          0, 0);

    // Async reset in the second MUL cycle, then a full-length MUL afterwards
    applyStimulus("rst_mul",     4'hD, 3'd0, 3'd0, 3'd0, 0, 1, 0, ref_dec(4'hD), 1, 0);
    applyStimulus("rst_hold",    4'h8, 3'd0, 3'd0, 3'd0, 0, 0, 0, ref_dec(4'hD), 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    compare("async_rst/ex", observed(), 17'd0);
    compare("async_rst/pc_write", 17'(pc_write), 17'd1);
    applyReset();
    applyStimulus("post_mul",    4'hD, 3'd0, 3'd0, 3'd0, 0, 1, 0, ref_dec(4'hD), 1, 0);
    for (int k = 0; k < 3; k++)
      applyStimulus("post_hold", 4'h0, 3'd0, 3'd0, 3'd0, 0, 0, 0, ref_dec(4'hD), k < 2, k == 2);
    applyStimulus("post_next",   4'h0, 3'd0, 3'd0, 3'd0, 0, 1, 0, ZERO,          0, 0);

    // Opcode sweep
    for (int i = 0; i < 16; i++) begin
      applyStimulus($sformatf("op_%0h", i), i[3:0], 3'd0, 3'd0, 3'd0, 0, 1, i == 1,
                    ref_dec(i[3:0]), i == 13, 0);
      if (i == 13)
        for (int k = 0; k < 3; k++)
          applyStimulus("sweep_drain", 4'h0, 3'd0, 3'd0, 3'd0, 0, 0, 0, ref_dec(4'hD), k < 2, k == 2);
    end

    compare("scoreboard_empty", 17'(sb.size()), 17'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Parametrised, sequenced successor to the pipeline's combinational opcode decoder. It decodes the 4-bit opcode in ID and registers the resulting control bundle into the ID/EX stage. It also owns hazard sequencing:
- load-use stall,
- branch/jump flush,
- a multi-cycle MUL operation that holds EX for a configurable number of cycles.

It sits between the IF/ID register and the EX stage and drives the PC and IF/ID write enables.

## Interface
- REG_AW, 3, register-address width for hazard comparison
- MUL_CYCLES, 4, cycles a MUL occupies EX (≥1)
- MUL_OP, 4'b1101, opcode treated as multi-cycle
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_op  in  4  opcode of instruction in IF/ID
- id_rs, id_rt  in  REG_AW  source registers of ID instruction
- ex_rd  in  REG_AW  destination register of EX instruction
- branch_taken  in  1  branch resolved taken in EX (pcsrc)
- pc_write, if_id_write  out  1  PC / IF/ID enables, combinational
- if_id_flush  out  1  zero IF/ID on next edge, combinational
- ex_reg_dst  out  2  registered; 01 = rd2 form, 10 = link reg
- ex_alu_op  out  3  registered
- ex_beq, ex_bgt, ex_ble  out  1  registered branch types
- ex_mem_read, ex_mem_write, ex_reg_write, ex_se_op  out  1  registered
- ex_mem_to_reg  out  2  registered; 01 = memory, 10 = PC+1
- ex_is_mul, mul_busy, mul_done  out  1  registered MUL flag; busy = counter≠0; done = last MUL cycle

## Operation
- Decode map (comb, ID):
  - 0000: NOP. 0111: reserved, decoded as NOP.
  - 0001: JMP. Asserts if_id_flush only; writes no ID/EX control.
  - 0010: BEQ (ex_beq, alu_op 001).
  - 0011: BGT (ex_bgt, alu_op 001).
  - 0100: BLE (ex_ble, alu_op 001).
  - 0101: LD (mem_read, mem_to_reg 01, reg_write).
  - 0110: ST (mem_write).
  - 1000–1110: ALU ops with reg_write, alu_op = op[2:0]. 1100 and 1101 also set se_op.
  - 1011: additionally reg_dst 10, mem_to_reg 10.
  - 1111: reg_write, reg_dst 01, alu_op 111.
  - MUL_OP sets is_mul.
- Load-use hazard: ex_mem_read & ex_rd≠0 & (ex_rd==id_rs | ex_rd==id_rt). Effects:
  - pc_write=0, if_id_write=0.
  - ID/EX loads a bubble (all control 0).
- MUL: on the edge MUL enters ID/EX, the counter loads MUL_CYCLES−1. While the counter≠0:
  - pc_write=0, if_id_write=0.
  - ID/EX holds its content.
  - The counter decrements each edge.
- mul_done = ex_is_mul & counter==0 (comb from registered state).
- branch_taken effects:
  - if_id_flush=1.
  - ID/EX loads a bubble.
  - pc_write=1.
  - The counter clears.
- Priority: reset > branch_taken > MUL busy > load-use > normal decode.
- if_id_flush = branch_taken | (id_op==0001 & ~mul_busy).
- Counter width: $clog2(MUL_CYCLES)+1. When MUL_CYCLES=1 there is never a stall.

## Timing
- Reset (async assert, sync release): every ex_* output is 0, mul_busy=0, mul_done=0, counter=0.
  - pc_write=1 and if_id_write=1 when no hazard is present.
- Decode-to-EX latency: 1 cycle (ID at edge n → ex_* valid after edge n).
- Load-use stall lasts exactly 1 cycle. The bubble clears ex_mem_read, so the same ID instruction issues next cycle.
- MUL occupies EX for exactly MUL_CYCLES cycles. The following instruction enters EX MUL_CYCLES edges after MUL entered.
- Back-to-back MULs: the second reloads the counter on its entry edge. The stream has no idle gap beyond MUL_CYCLES per MUL.
- Load-use with MUL in EX: busy dominates. The hazard is re-evaluated once busy drops.
- branch_taken during busy is a protocol error. The flush still wins and the counter resets to 0.
- Reset mid-MUL: counter, is_mul and busy clear immediately (async).

## Test plan
- Reset with all inputs 0 → all ex_* =0, pc_write=1, if_id_write=1, if_id_flush=0; release then id_op=0101 → next cycle ex_mem_read=1, ex_mem_to_reg=01, ex_reg_write=1.
- LD r3 in EX (ex_mem_read=1, ex_rd=3), id_rs=3 → pc_write=0 and if_id_write=0 for 1 cycle, next ex_* all 0; same with ex_rd=0 → no stall.
- MUL_CYCLES=4, id_op=1101 → ex_is_mul=1 for 4 cycles, mul_busy high for 3, mul_done on the 4th, pc_write=0 for exactly 3 cycles; repeat with MUL_CYCLES=1 → no stall.
- id_op=0001 → if_id_flush=1, next ex_* all 0; branch_taken=1 with id_op=1000 → if_id_flush=1, next ex_* all 0.
- Async rst_n low at 2nd MUL cycle → mul_busy, ex_is_mul drop without clock edge; after release a new MUL counts full MUL_CYCLES.
- Sweep all 16 opcodes → ex_* fields match the decode map, 0111 and 0000 give all-zero control.
